wb_regfile: RTL and testbench

Architectural register file for the processor, consuming the write-back stage. Each cycle it takes the MEM/WB pipeline register outputs (write enable, mem-to-reg select, destination address, ALU result) together with the data-memory read word. It selects the write-back value and commits it to the register array. It also serves the two decode-stage read ports with write-first bypass, and keeps a commit pulse and a commit counter for debug and performance observation.

---
 rtl/wb_regfile.sv | 117 +++++++++++
 tb/tb_wb_regfile.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: architectural register file fed by the write-back stage.
//
// Picks the write-back value (ALU result or memory word), commits it into the
// register array, and serves two decode read ports with write-first bypass.
// A third debug port reads the raw array without bypass. Commit pulse, last
// commit address and a wrapping commit counter are kept for observation.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   reg_write_en_i       write-back enable from MEM/WB
//   mem_to_reg_i         1: write mem_data_i, 0: write alu_i
//   reg_write_addr_i     destination register
//   alu_i, mem_data_i    candidate write-back values
//   rd_addr_a_i/_b_i     read port addresses (bypassed)
//   dbg_addr_i           debug read address (no bypass)
//   rd_data_a_o/_b_o     read port data
//   dbg_data_o           raw array content at dbg_addr_i
//   wb_data_o            selected write-back value (combinational)
//   wb_commit_o          high the cycle after a committed write
//   wb_commit_addr_o     address of the last committed write
//   commit_count_o       number of committed writes, wrapping

module wb_regfile #(
    parameter int unsigned PROC_DATA_WIDTH        = 16,
    parameter int unsigned PROC_REGFILE_LOG2_DEEP = 5,
    parameter int unsigned COMMIT_CNT_WIDTH       = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              reg_write_en_i,
    input  logic                              mem_to_reg_i,
    input  logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_i,
    input  logic [PROC_DATA_WIDTH-1:0]        alu_i,
    input  logic [PROC_DATA_WIDTH-1:0]        mem_data_i,
    input  logic [PROC_REGFILE_LOG2_DEEP-1:0] rd_addr_a_i,
    input  logic [PROC_REGFILE_LOG2_DEEP-1:0] rd_addr_b_i,
    input  logic [PROC_REGFILE_LOG2_DEEP-1:0] dbg_addr_i,
    output logic [PROC_DATA_WIDTH-1:0]        rd_data_a_o,
    output logic [PROC_DATA_WIDTH-1:0]        rd_data_b_o,
    output logic [PROC_DATA_WIDTH-1:0]        dbg_data_o,
    output logic [PROC_DATA_WIDTH-1:0]        wb_data_o,
    output logic                              wb_commit_o,
    output logic [PROC_REGFILE_LOG2_DEEP-1:0] wb_commit_addr_o,
    output logic [COMMIT_CNT_WIDTH-1:0]       commit_count_o
);

    localparam int unsigned Depth = 2 ** PROC_REGFILE_LOG2_DEEP;

    logic [PROC_DATA_WIDTH-1:0]        regs_q [Depth];
    logic                              commit;
    logic                              commit_q;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] commit_addr_q;
    logic [COMMIT_CNT_WIDTH-1:0]       commit_count_q;

    assign wb_data_o = mem_to_reg_i ? mem_data_i : alu_i;

    // Register 0 is never written, so it is not a commit.
    assign commit = reg_write_en_i && (reg_write_addr_i != '0);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[reg_write_addr_i] <= wb_data_o;
        end
    end

    // Write-first bypass: a port reading the register being committed this
    // cycle sees the new value immediately.
    always_comb begin
        rd_data_a_o = regs_q[rd_addr_a_i];
        if (rd_addr_a_i == '0) begin
            rd_data_a_o = '0;
        end else if (commit && (rd_addr_a_i == reg_write_addr_i)) begin
            rd_data_a_o = wb_data_o;
        end
    end

    always_comb begin
        rd_data_b_o = regs_q[rd_addr_b_i];
        if (rd_addr_b_i == '0) begin
            rd_data_b_o = '0;
        end else if (commit && (rd_addr_b_i == reg_write_addr_i)) begin
            rd_data_b_o = wb_data_o;
        end
    end

    // Debug sees the array only: the pre-write value during a commit cycle.
    always_comb begin
        dbg_data_o = regs_q[dbg_addr_i];
        if (dbg_addr_i == '0) begin
            dbg_data_o = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            commit_q       <= 1'b0;
            commit_addr_q  <= '0;
            commit_count_q <= '0;
        end else begin
            commit_q <= commit;
            if (commit) begin
                commit_addr_q  <= reg_write_addr_i;
                commit_count_q <= commit_count_q + COMMIT_CNT_WIDTH'(1);
            end
        end
    end

    assign wb_commit_o      = commit_q;
    assign wb_commit_addr_o = commit_addr_q;
    assign commit_count_o   = commit_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile. Two instances share stimulus:
// one with the default 16-bit commit counter, one with a 4-bit counter to
// exercise wrap-around.

module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic        m2r;
    logic [4:0]  waddr;
    logic [15:0] alu;
    logic [15:0] mem;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  da;

    logic [15:0] rd_a, rd_b, dbg, wbd;
    logic        cm;
    logic [4:0]  cm_addr;
    logic [15:0] cnt;

    logic [15:0] rd_a4, rd_b4, dbg4, wbd4;
    logic        cm4;
    logic [4:0]  cm_addr4;
    logic [3:0]  cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .reg_write_en_i   (we),
        .mem_to_reg_i     (m2r),
        .reg_write_addr_i (waddr),
        .alu_i            (alu),
        .mem_data_i       (mem),
        .rd_addr_a_i      (ra),
        .rd_addr_b_i      (rb),
        .dbg_addr_i       (da),
        .rd_data_a_o      (rd_a),
        .rd_data_b_o      (rd_b),
        .dbg_data_o       (dbg),
        .wb_data_o        (wbd),
        .wb_commit_o      (cm),
        .wb_commit_addr_o (cm_addr),
        .commit_count_o   (cnt)
    );

    wb_regfile #(
        .COMMIT_CNT_WIDTH (4)
    ) dut_w4 (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .reg_write_en_i   (we),
        .mem_to_reg_i     (m2r),
        .reg_write_addr_i (waddr),
        .alu_i            (alu),
        .mem_data_i       (mem),
        .rd_addr_a_i      (ra),
        .rd_addr_b_i      (rb),
        .dbg_addr_i       (da),
        .rd_data_a_o      (rd_a4),
        .rd_data_b_o      (rd_b4),
        .dbg_data_o       (dbg4),
        .wb_data_o        (wbd4),
        .wb_commit_o      (cm4),
        .wb_commit_addr_o (cm_addr4),
        .commit_count_o   (cnt4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Commit one value: inputs held across one rising edge, enable dropped after.
    task automatic do_write(input logic [4:0] a, input logic [15:0] d, input logic sel_mem);
        we    = 1'b1;
        waddr = a;
        m2r   = sel_mem;
        if (sel_mem) begin
            mem = d;
            alu = ~d;
        end else begin
            alu = d;
            mem = ~d;
        end
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        we = 1'b0; m2r = 1'b0; waddr = '0; alu = '0; mem = '0;
        ra = '0; rb = '0; da = 5'd3;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_commit", {31'b0, cm}, 32'd0);
        check_eq("rst_caddr", {27'b0, cm_addr}, 32'd0);
        check_eq("rst_count", {16'b0, cnt}, 32'd0);
        check_eq("rst_count_w4", {28'b0, cnt4}, 32'd0);
        check_eq("rst_dbg", {16'b0, dbg}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Populate a few registers, then reset between edges.
        do_write(5'd1, 16'h1111, 1'b0);
        do_write(5'd2, 16'h2222, 1'b0);
        do_write(5'd3, 16'h3333, 1'b1);
        ra = 5'd1; rb = 5'd3; da = 5'd2;
        #1;
        check_eq("pre_rst_dbg2", {16'b0, dbg}, 32'h2222);
        check_eq("pre_rst_rdb3", {16'b0, rd_b}, 32'h3333);
        check_eq("pre_rst_count", {16'b0, cnt}, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_rst_rda", {16'b0, rd_a}, 32'd0);
        check_eq("async_rst_rdb", {16'b0, rd_b}, 32'd0);
        check_eq("async_rst_dbg", {16'b0, dbg}, 32'd0);
        check_eq("async_rst_commit", {31'b0, cm}, 32'd0);
        check_eq("async_rst_caddr", {27'b0, cm_addr}, 32'd0);
        check_eq("async_rst_count", {16'b0, cnt}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            da = 5'(i);
            #0.1;
            check_eq($sformatf("rst_dbg_%0d", i), {16'b0, dbg}, 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU write with bypass on port A.
        we = 1'b1; waddr = 5'd5; m2r = 1'b0; alu = 16'h1234; mem = 16'h9999;
        ra = 5'd5; da = 5'd5;
        #1;
        check_eq("alu_wbdata", {16'b0, wbd}, 32'h1234);
        check_eq("alu_bypass_a", {16'b0, rd_a}, 32'h1234);
        check_eq("alu_dbg_pre", {16'b0, dbg}, 32'd0);
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        check_eq("alu_dbg_post", {16'b0, dbg}, 32'h1234);
        check_eq("alu_rda_post", {16'b0, rd_a}, 32'h1234);
        check_eq("alu_commit", {31'b0, cm}, 32'd1);
        check_eq("alu_caddr", {27'b0, cm_addr}, 32'd5);
        check_eq("alu_count", {16'b0, cnt}, 32'd1);

        // Memory-sourced write.
        we = 1'b1; waddr = 5'd31; m2r = 1'b1; mem = 16'hBEEF; alu = 16'h0001;
        #1;
        check_eq("mem_wbdata", {16'b0, wbd}, 32'hBEEF);
        @(posedge clk); #1;
        we = 1'b0; rb = 5'd31;
        #1;
        check_eq("mem_rdb31", {16'b0, rd_b}, 32'hBEEF);
        check_eq("mem_count", {16'b0, cnt}, 32'd2);
        check_eq("mem_caddr", {27'b0, cm_addr}, 32'd31);

        // Register 0 write is discarded.
        we = 1'b1; waddr = 5'd0; m2r = 1'b0; alu = 16'hFFFF; ra = 5'd0; da = 5'd0;
        #1;
        check_eq("r0_rda_same", {16'b0, rd_a}, 32'd0);
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        check_eq("r0_rda_next", {16'b0, rd_a}, 32'd0);
        check_eq("r0_dbg", {16'b0, dbg}, 32'd0);
        check_eq("r0_commit", {31'b0, cm}, 32'd0);
        check_eq("r0_count", {16'b0, cnt}, 32'd2);
        check_eq("r0_caddr_hold", {27'b0, cm_addr}, 32'd31);

        // Dual-port bypass on the same address.
        we = 1'b1; waddr = 5'd7; m2r = 1'b0; alu = 16'h00AA; ra = 5'd7; rb = 5'd7; da = 5'd7;
        #1;
        check_eq("dual_a_byp", {16'b0, rd_a}, 32'h00AA);
        check_eq("dual_b_byp", {16'b0, rd_b}, 32'h00AA);
        we = 1'b0;
        #1;
        check_eq("dual_a_nowe", {16'b0, rd_a}, 32'd0);
        check_eq("dual_b_nowe", {16'b0, rd_b}, 32'd0);
        do_write(5'd7, 16'h00AA, 1'b0);
        we = 1'b1; waddr = 5'd7; alu = 16'h0055;
        #1;
        check_eq("dual_a_byp2", {16'b0, rd_a}, 32'h0055);
        check_eq("dual_b_byp2", {16'b0, rd_b}, 32'h0055);
        check_eq("dual_dbg_old", {16'b0, dbg}, 32'h00AA);
        we = 1'b0;
        #1;
        check_eq("dual_a_old", {16'b0, rd_a}, 32'h00AA);
        check_eq("dual_b_old", {16'b0, rd_b}, 32'h00AA);
        check_eq("dual_count", {16'b0, cnt}, 32'd3);

        // Unknown select while disabled must leave the array alone.
        we = 1'b0; m2r = 1'bx; waddr = 5'd7; alu = 16'h0F0F; mem = 16'hF0F0;
        @(posedge clk); #1;
        m2r = 1'b0;
        check_eq("x_sel_dbg7", {16'b0, dbg}, 32'h00AA);
        check_eq("x_sel_count", {16'b0, cnt}, 32'd3);

        // Back-to-back commits to one address.
        da = 5'd9;
        we = 1'b1; waddr = 5'd9; m2r = 1'b0;
        alu = 16'h0001; @(posedge clk); #1;
        alu = 16'h0002; @(posedge clk); #1;
        alu = 16'h0003; @(posedge clk); #1;
        we = 1'b0;
        #1;
        check_eq("b2b_dbg9", {16'b0, dbg}, 32'h0003);
        check_eq("b2b_count", {16'b0, cnt}, 32'd6);
        check_eq("b2b_count_w4", {28'b0, cnt4}, 32'd6);

        // Counter wrap on the 4-bit instance: 17 commits leave 1.
        rst_n = 1'b0;
        #1;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            do_write(5'((i % 31) + 1), 16'(i + 16'h100), 1'b0);
        end
        check_eq("wrap_count_w4", {28'b0, cnt4}, 32'd1);
        check_eq("wrap_count", {16'b0, cnt}, 32'd17);
        check_eq("wrap_caddr", {27'b0, cm_addr}, 32'd17);

        // A write held across a reset edge is discarded; first edge after
        // release commits.
        we = 1'b1; waddr = 5'd10; m2r = 1'b0; alu = 16'h0077; da = 5'd10;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk) rst_n = 1'b1;
        #1;
        check_eq("rstw_dbg_pre", {16'b0, dbg}, 32'd0);
        check_eq("rstw_count_pre", {16'b0, cnt}, 32'd0);
        @(posedge clk); #1;
        we = 1'b0;
        check_eq("rstw_dbg_post", {16'b0, dbg}, 32'h0077);
        check_eq("rstw_count_post", {16'b0, cnt}, 32'd1);
        check_eq("rstw_commit", {31'b0, cm}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
